// File: rtl/compound_txn_master.sv
`default_nettype none
// ============================================================================
// Module      : compound_txn_master
// Description : CompoundType initiator. Issues a numbered request sequence and
//               checks in-order responses against an expected-response FIFO.
//               Payload layout on req_out/rsp_in: {mode(1=write), x[31:0], y}.
// Revision    : 1.0 - initial release
// ============================================================================
module compound_txn_master #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_x,
    input  logic [CNT_W-1:0] num_txn,
    output logic [33:0]      req_out,
    input  logic             req_out_sync,
    output logic             req_out_notify,
    input  logic [33:0]      rsp_in,
    input  logic             rsp_in_sync,
    output logic             rsp_in_notify,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] txn_sent,
    output logic [CNT_W-1:0] rsp_rcvd,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]       r_state,  w_state_nxt;
    logic [33:0]      r_req,    w_req_nxt;
    logic             r_req_vld, w_req_vld_nxt;
    logic             r_rsp_rdy, w_rsp_rdy_nxt;
    logic             r_busy,   w_busy_nxt;
    logic             r_done,   w_done_nxt;
    logic [31:0]      r_base,   w_base_nxt;
    logic [CNT_W-1:0] r_num,    w_num_nxt;
    logic [CNT_W-1:0] r_sent,   w_sent_nxt;
    logic [CNT_W-1:0] r_rcvd,   w_rcvd_nxt;
    logic [CNT_W-1:0] r_err,    w_err_nxt;
    logic [CNT_W-1:0] r_first,  w_first_nxt;

    logic [33:0]      r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic [c_CW-1:0]  w_count_nxt;

    logic             w_push;
    logic             w_pop;
    logic             w_mismatch;

    // Transaction i: write on even i, x = base + i (wrapping), y = bit 1 of i.
    function automatic logic [33:0] f_txn(input logic [31:0] base,
                                          input logic [CNT_W-1:0] idx);
        return {~idx[0], base + 32'(idx), idx[1]};
    endfunction

    assign w_push      = r_req_vld & req_out_sync;
    assign w_pop       = r_rsp_rdy & rsp_in_sync;
    assign w_mismatch  = w_pop && (r_mem[r_rd_ptr] != rsp_in);
    assign w_count_nxt = r_count + c_CW'(w_push) - c_CW'(w_pop);

    always_comb begin
        w_state_nxt   = r_state;
        w_req_nxt     = r_req;
        w_req_vld_nxt = 1'b0;
        w_rsp_rdy_nxt = 1'b0;
        w_base_nxt    = r_base;
        w_num_nxt     = r_num;
        w_sent_nxt    = r_sent + CNT_W'(w_push);
        w_rcvd_nxt    = r_rcvd + CNT_W'(w_pop);
        w_err_nxt     = r_err;
        w_first_nxt   = r_first;

        if (w_mismatch) begin
            if (r_err != '1) begin
                w_err_nxt = r_err + 1'b1;
            end
            if (r_err == '0) begin
                w_first_nxt = r_rcvd;
            end
        end

        case (r_state)
            c_IDLE, c_DONE: begin
                if (start) begin
                    w_base_nxt  = base_x;
                    w_num_nxt   = num_txn;
                    w_sent_nxt  = '0;
                    w_rcvd_nxt  = '0;
                    w_err_nxt   = '0;
                    w_first_nxt = '1;
                    w_req_nxt   = f_txn(base_x, '0);
                    if (num_txn == '0) begin
                        w_state_nxt = c_DONE;
                    end else begin
                        w_state_nxt   = c_RUN;
                        w_req_vld_nxt = 1'b1;
                    end
                end
            end
            c_RUN: begin
                if (w_push) begin
                    w_req_nxt = f_txn(r_base, w_sent_nxt);
                end
                w_req_vld_nxt = (w_sent_nxt < r_num) && (w_count_nxt < c_DEPTH);
                w_rsp_rdy_nxt = (w_count_nxt != '0);
                if (w_sent_nxt == r_num) begin
                    w_state_nxt = c_DRAIN;
                end
            end
            c_DRAIN: begin
                w_rsp_rdy_nxt = (w_count_nxt != '0);
                if (w_count_nxt == '0) begin
                    w_state_nxt = c_DONE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == c_RUN) || (w_state_nxt == c_DRAIN);
        w_done_nxt = (w_state_nxt == c_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_req     <= '0;
            r_req_vld <= 1'b0;
            r_rsp_rdy <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_base    <= '0;
            r_num     <= '0;
            r_sent    <= '0;
            r_rcvd    <= '0;
            r_err     <= '0;
            r_first   <= '1;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_req     <= w_req_nxt;
            r_req_vld <= w_req_vld_nxt;
            r_rsp_rdy <= w_rsp_rdy_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_base    <= w_base_nxt;
            r_num     <= w_num_nxt;
            r_sent    <= w_sent_nxt;
            r_rcvd    <= w_rcvd_nxt;
            r_err     <= w_err_nxt;
            r_first   <= w_first_nxt;
            r_count   <= w_count_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by r_count and the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_req;
        end
    end

    assign req_out        = r_req;
    assign req_out_notify = r_req_vld;
    assign rsp_in_notify  = r_rsp_rdy;
    assign busy           = r_busy;
    assign done           = r_done;
    assign txn_sent       = r_sent;
    assign rsp_rcvd       = r_rcvd;
    assign err_cnt        = r_err;
    assign first_err_idx  = r_first;

endmodule
`default_nettype wire
